cpa_pipe_adder: RTL and testbench

//   Elastic 2-stage carry-propagate adder: sum = a + b + cin, with valid/ready on both sides.
//   S1 forms and registers the generate/propagate vectors; S2 feeds them to the lookahead carry

---
 rtl/cpa_pkg.sv | 16 +
 rtl/gp_carry_net.sv | 22 ++
 rtl/cpa_pipe_adder.sv | 114 +++++++++++
 tb/tb_cpa_pipe_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpa_pkg.sv
// Shared types and default width for the pipelined carry-propagate adder.
package cpa_pkg;

    localparam int CPA_W = 8;

    typedef struct packed {
        logic [CPA_W:0] g;
        logic [CPA_W:1] p;
    } gp_t;

    typedef struct packed {
        logic [CPA_W-1:0] sum;
        logic             cout;
    } result_t;

endpackage

// File: rtl/gp_carry_net.sv
// Combinational lookahead carry network: g/p vectors in, carries c[W:0] out.
module gp_carry_net #(
    parameter int W = 8
) (
    input  logic [W:0] g_i,
    input  logic [W:1] p_i,
    output logic [W:0] c_o
);

    logic [W:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = g_i[0];
        for (int k = 1; k <= W; k++) begin
            carry[k] = g_i[k] | (p_i[k] & carry[k-1]);
        end
    end

    assign c_o = carry;

endmodule

// File: rtl/cpa_pipe_adder.sv
// Elastic two-stage adder: S1 registers generate/propagate, S2 registers sum/cout.
// Define CPA_OVF_EN to add the registered signed-overflow output ovf.
module cpa_pipe_adder
    import cpa_pkg::*;
#(
    parameter int W = CPA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef CPA_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Same layout as the package gp_t, sized by this instance's W.
    typedef struct packed {
        logic [W:0] g;
        logic [W:1] p;
    } gp_w_t;

    gp_w_t        gp_d, gp_q;
    logic         s1_valid_d, s1_valid_q;
    logic         s2_valid_d, s2_valid_q;
    logic [W-1:0] sum_d, sum_q;
    logic         cout_d, cout_q;
    logic [W:0]   c;
    logic         s1_load;
    logic         s2_adv;
`ifdef CPA_OVF_EN
    logic         ovf_d, ovf_q;
`endif

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign s1_load  = in_valid & in_ready;

    assign gp_d.g = {a & b, cin};
    assign gp_d.p = a ^ b;

    gp_carry_net #(
        .W (W)
    ) u_carry_net (
        .g_i (gp_q.g),
        .p_i (gp_q.p),
        .c_o (c)
    );

    // p[i+1] lines up with c[i] once both are taken LSB-first.
    assign sum_d  = gp_q.p ^ c[W-1:0];
    assign cout_d = c[W];
`ifdef CPA_OVF_EN
    assign ovf_d  = c[W] ^ c[W-1];
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            gp_q       <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
`ifdef CPA_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                gp_q <= gp_d;
            end
            if (s2_adv) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef CPA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CPA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cpa_pipe_adder.sv
// Self-checking bench for cpa_pipe_adder: vector table, directed handshake sequences, random scoreboard.
module tb_cpa_pipe_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CPA_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    cpa_pipe_adder #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CPA_OVF_EN
        ,.ovf      (ovf)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [9:0] exp; // {ovf, cout, sum}
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string nm, input logic [9:0] e);
        chk({nm, "_sum"}, 32'(sum), 32'(e[7:0]));
        chk({nm, "_cout"}, 32'(cout), 32'(e[8]));
`ifdef CPA_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(e[9]));
`endif
    endtask

    // Reference: plain integer addition, signed overflow from the signed range.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int u;
        int s;
        logic [9:0] r;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        r[7:0] = u[7:0];
        r[8]   = u[8];
        r[9]   = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [9:0] dummy, input logic [16:0] abc);
        in_valid = v;
        a        = abc[16:9];
        b        = abc[8:1];
        cin      = abc[0];
    endtask

    vec_t        vecs[10];
    logic [16:0] beats[16];
    logic [9:0]  q[$];
    logic [9:0]  e;
    logic [7:0]  hold_sum;
    logic        hold;
    int          occ;
    int          acc;
    int          cyc;
    int          n;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}};
        vecs[2] = '{8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00}};
        vecs[3] = '{8'h00, 8'h00, 1'b1, {1'b0, 1'b0, 8'h01}};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF}};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, {1'b0, 1'b0, 8'hFF}};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, {1'b0, 1'b1, 8'h00}};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, {1'b1, 1'b0, 8'hFF}};
        vecs[8] = '{8'h3C, 8'hC3, 1'b0, {1'b0, 1'b0, 8'hFF}};
        vecs[9] = '{8'h01, 8'h02, 1'b1, {1'b0, 1'b0, 8'h04}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single beats from the table, two-cycle latency each.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, '0, {vecs[i].a, vecs[i].b, vecs[i].cin});
            out_ready = 1'b1;
            #1;
            chk("tab_in_ready", 32'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            #1;
            chk("tab_lat1_valid", 32'(out_valid), 0);
            tick();
            #1;
            chk("tab_lat2_valid", 32'(out_valid), 1);
            chk_res($sformatf("tab%0d", i), vecs[i].exp);
            tick();
            #1;
            chk("tab_drained", 32'(out_valid), 0);
        end

        // Back-to-back 16 beats at full throughput.
        for (int i = 0; i < 16; i++) beats[i] = 17'($urandom);
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) drive(1'b1, '0, beats[k]);
            else in_valid = 1'b0;
            #1;
            chk("b2b_in_ready", 32'(in_ready), 1);
            if (k >= 2) begin
                chk("b2b_valid", 32'(out_valid), 1);
                chk_res("b2b", ref_add(beats[k-2][16:9], beats[k-2][8:1], beats[k-2][0]));
            end
            tick();
        end
        #1;
        chk("b2b_end_valid", 32'(out_valid), 0);
        tick();

        // Stall with out_ready low, then release with a simultaneous new beat.
        for (int i = 0; i < 4; i++) beats[i] = 17'($urandom);
        out_ready = 1'b0;
        drive(1'b1, '0, beats[0]); #1;
        chk("stall_k0_ready", 32'(in_ready), 1);
        tick();
        drive(1'b1, '0, beats[1]); #1;
        chk("stall_k1_ready", 32'(in_ready), 1);
        chk("stall_k1_valid", 32'(out_valid), 0);
        tick();
        drive(1'b1, '0, beats[3]); #1;
        chk("stall_k2_ready", 32'(in_ready), 0);
        chk("stall_k2_valid", 32'(out_valid), 1);
        chk_res("stall_k2", ref_add(beats[0][16:9], beats[0][8:1], beats[0][0]));
        tick();
        drive(1'b1, '0, ~beats[3]); #1;
        chk("stall_k3_ready", 32'(in_ready), 0);
        chk_res("stall_k3_hold", ref_add(beats[0][16:9], beats[0][8:1], beats[0][0]));
        tick();
        drive(1'b1, '0, beats[2]);
        out_ready = 1'b1; #1;
        chk("stall_k4_ready", 32'(in_ready), 1);
        chk_res("stall_k4", ref_add(beats[0][16:9], beats[0][8:1], beats[0][0]));
        tick();
        in_valid = 1'b0; #1;
        chk("stall_k5_valid", 32'(out_valid), 1);
        chk_res("stall_k5", ref_add(beats[1][16:9], beats[1][8:1], beats[1][0]));
        tick();
        #1;
        chk("stall_k6_valid", 32'(out_valid), 1);
        chk_res("stall_k6", ref_add(beats[2][16:9], beats[2][8:1], beats[2][0]));
        tick();
        #1;
        chk("stall_k7_valid", 32'(out_valid), 0);
        tick();

        // Reset while both stages are full.
        out_ready = 1'b0;
        drive(1'b1, '0, 17'h1_FE_03);
        tick();
        tick();
        #1;
        chk("rstmid_full_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(out_valid), 0);
        chk("rstmid_sum", 32'(sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, '0, {8'h12, 8'h34, 1'b1});
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (out_valid) begin
                n++;
                chk_res("rstmid_beat", {1'b0, 1'b0, 8'h47});
            end
            tick();
        end
        chk("rstmid_count", n, 1);

        // Random traffic against a queue scoreboard.
        occ  = 0;
        acc  = 0;
        cyc  = 0;
        hold = 1'b0;
        hold_sum = '0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
            if (hold) begin
                chk("rnd_hold_valid", 32'(out_valid), 1);
                chk("rnd_hold_sum", 32'(sum), 32'(hold_sum));
            end
            if (q.size() == 0) begin
                chk("rnd_valid_empty", 32'(out_valid), 0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk_res("rnd", e);
                occ--;
            end
            hold     = out_valid && !out_ready;
            hold_sum = sum;
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, cin));
                occ++;
                acc++;
            end
            tick();
            cyc++;
        end
        chk("rnd_accepted", acc, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (out_valid && q.size() != 0) begin
                e = q.pop_front();
                chk_res("rnd_drain", e);
            end
            tick();
        end
        chk("rnd_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
